// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the main-memory port arbiter.
// Holds the response-owner encoding and the default starvation limit.
package mem_port_arbiter_pkg;

  localparam int unsigned MEM_PORT_MAX_STARVE = 3;
  localparam int unsigned STARVE_W            = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_state_t;

  // Owner of the response that returns one cycle after this cycle's grant.
  function automatic rsp_state_t next_rsp(input logic if_gnt, input logic d_gnt, input logic d_we);
    rsp_state_t r;
    r = RSP_NONE;
    if (if_gnt) begin
      r = RSP_IF;
    end else if (d_gnt && !d_we) begin
      r = RSP_D;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_arb_starve_counter.sv
// Saturating denial counter: counts up on inc, clears on clr, flags sat at MAX.
// Clear wins over increment; the count parks at MAX until cleared.
module mem_arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX = MEM_PORT_MAX_STARVE
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [STARVE_W-1:0] cnt;

  assign sat = (cnt == STARVE_W'(MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + STARVE_W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single main-memory port between instruction fetch and data access.
// D has fixed priority; IF is forced through after MAX_STARVE consecutive denials.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_STARVE = MEM_PORT_MAX_STARVE,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wen,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic       force_if;
  logic       starve_inc;
  logic       starve_clr;
  rsp_state_t rsp_state;
  rsp_state_t rsp_next;

  mem_arb_starve_counter #(
    .MAX (MAX_STARVE)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (starve_inc),
    .clr (starve_clr),
    .sat (force_if)
  );

  assign starve_inc = if_req && !if_gnt;
  assign starve_clr = !if_req || if_gnt;

  // Grant selection: forced IF, then D, then IF.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (force_if && if_req) begin
      if_gnt = 1'b1;
    end else if (d_req) begin
      d_gnt = 1'b1;
    end else if (if_req) begin
      if_gnt = 1'b1;
    end
  end

  // Port drive for the granted operation; idle port presents zeros.
  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    if (if_gnt) begin
      mem_raddr = if_addr;
    end else if (d_gnt && d_we) begin
      mem_waddr = d_addr;
      mem_wdata = d_wdata;
      mem_wen   = 1'b1;
    end else if (d_gnt) begin
      mem_raddr = d_addr;
    end
  end

  assign rsp_next = next_rsp(if_gnt, d_gnt, d_we);

  // Response owner; stores and idle cycles produce no response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_state <= RSP_NONE;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
    end else begin
      rsp_state <= rsp_next;
      if_rvalid <= (rsp_next == RSP_IF);
      d_rvalid  <= (rsp_next == RSP_D);
    end
  end

  assign if_rdata = if_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand sequences and random
// traffic checked against a rule-level model with its own shadow memory.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned MAXS = 3;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .MAX_STARVE (MAXS),
    .ADDR_W     (32),
    .DATA_W     (32)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_gnt     (d_gnt),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Main memory: 256 words, read data one cycle after address, preloaded on reset.
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < 256; n++) mem[n] <= 32'(n + 100);
      mem[40]   <= 32'd7;
      mem_rdata <= '0;
    end else begin
      if (mem_wen) mem[mem_waddr[7:0]] <= mem_wdata;
      mem_rdata <= mem[mem_raddr[7:0]];
    end
  end

  a_onehot: assert property (@(posedge clk) !(if_gnt && d_gnt))
    else $error("both grants high");
  a_if_hold: assert property (@(posedge clk) disable iff (rst)
    (if_req && !if_gnt) |=> (!if_req || $stable(if_addr)))
    else $error("if_addr changed while request pending");
  a_d_hold: assert property (@(posedge clk) disable iff (rst)
    (d_req && !d_gnt) |=> (!d_req || ($stable(d_addr) && $stable(d_we) && $stable(d_wdata))))
    else $error("d request changed while pending");

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at t=%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: denial count, pending response owner/data, shadow memory.
  int          m_cnt;
  int          m_pend;
  logic [31:0] m_data;
  logic [31:0] ref_mem [0:255];
  logic        m_if_last;
  logic        m_d_last;

  task automatic model_reset();
    m_cnt     = 0;
    m_pend    = 0;
    m_data    = '0;
    m_if_last = 1'b0;
    m_d_last  = 1'b0;
    for (int n = 0; n < 256; n++) ref_mem[n] = 32'(n + 100);
    ref_mem[40] = 32'd7;
  endtask

  task automatic model_step();
    logic e_if;
    logic e_d;
    e_if = if_req && ((m_cnt >= int'(MAXS)) || !d_req);
    e_d  = d_req && !e_if;
    chk("if_gnt", 32'(if_gnt), 32'(e_if));
    chk("d_gnt", 32'(d_gnt), 32'(e_d));
    chk("mem_wen", 32'(mem_wen), 32'(e_d && d_we));
    if (e_if) chk("mem_raddr_if", mem_raddr, if_addr);
    else if (e_d && !d_we) chk("mem_raddr_d", mem_raddr, d_addr);
    else if (e_d) begin
      chk("mem_waddr", mem_waddr, d_addr);
      chk("mem_wdata", mem_wdata, d_wdata);
    end else chk("mem_raddr_idle", mem_raddr, 32'd0);
    chk("if_rvalid", 32'(if_rvalid), 32'(m_pend == 1));
    chk("if_rdata", if_rdata, (m_pend == 1) ? m_data : 32'd0);
    chk("d_rvalid", 32'(d_rvalid), 32'(m_pend == 2));
    chk("d_rdata", d_rdata, (m_pend == 2) ? m_data : 32'd0);
    if (e_if) begin
      m_pend = 1;
      m_data = ref_mem[if_addr[7:0]];
    end else if (e_d && !d_we) begin
      m_pend = 2;
      m_data = ref_mem[d_addr[7:0]];
    end else begin
      m_pend = 0;
    end
    if (e_d && d_we) ref_mem[d_addr[7:0]] = d_wdata;
    if (!if_req || e_if) m_cnt = 0;
    else if (m_cnt < int'(MAXS)) m_cnt = m_cnt + 1;
    m_if_last = e_if;
    m_d_last  = e_d;
  endtask

  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic dwe, input logic [31:0] da, input logic [31:0] dwd);
    if_req  = ir;
    if_addr = ia;
    d_req   = dr;
    d_we    = dwe;
    d_addr  = da;
    d_wdata = dwd;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        e_if_gnt;
    logic        e_d_gnt;
    logic        e_wen;
    logic        e_if_rv;
    logic [31:0] e_if_rd;
    logic        e_d_rv;
    logic [31:0] e_d_rd;
  } vec_t;

  function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                              input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
                              input logic eig, input logic edg, input logic ewen,
                              input logic eirv, input logic [31:0] eird,
                              input logic edrv, input logic [31:0] edrd);
    vec_t v;
    v.if_req = ir;  v.if_addr = ia;  v.d_req = dr;  v.d_we = dwe;
    v.d_addr = da;  v.d_wdata = dwd;
    v.e_if_gnt = eig;  v.e_d_gnt = edg;  v.e_wen = ewen;
    v.e_if_rv = eirv;  v.e_if_rd = eird;  v.e_d_rv = edrv;  v.e_d_rd = edrd;
    return v;
  endfunction

  vec_t tbl [10];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // IF stream, D/IF overlap, store then load of the same word.
    tbl[0] = mk(1, 0,  0, 0, 0,  0,            1, 0, 0, 0, 0,   0, 0);
    tbl[1] = mk(1, 1,  0, 0, 0,  0,            1, 0, 0, 1, 100, 0, 0);
    tbl[2] = mk(1, 2,  0, 0, 0,  0,            1, 0, 0, 1, 101, 0, 0);
    tbl[3] = mk(0, 0,  0, 0, 0,  0,            0, 0, 0, 1, 102, 0, 0);
    tbl[4] = mk(1, 5,  1, 0, 40, 0,            0, 1, 0, 0, 0,   0, 0);
    tbl[5] = mk(1, 5,  0, 0, 0,  0,            1, 0, 0, 0, 0,   1, 7);
    tbl[6] = mk(0, 0,  0, 0, 0,  0,            0, 0, 0, 1, 105, 0, 0);
    tbl[7] = mk(0, 0,  1, 1, 9,  32'hDEADBEEF, 0, 1, 1, 0, 0,   0, 0);
    tbl[8] = mk(0, 0,  1, 0, 9,  0,            0, 1, 0, 0, 0,   0, 0);
    tbl[9] = mk(0, 0,  0, 0, 0,  0,            0, 0, 0, 0, 0,   1, 32'hDEADBEEF);

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("reset_d_rvalid", 32'(d_rvalid), 32'd0);
    chk("reset_if_rdata", if_rdata, 32'd0);
    chk("reset_d_rdata", d_rdata, 32'd0);
    chk("reset_mem_wen", 32'(mem_wen), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].if_req, tbl[i].if_addr, tbl[i].d_req, tbl[i].d_we, tbl[i].d_addr, tbl[i].d_wdata);
      @(negedge clk);
      chk($sformatf("tbl%0d_if_gnt", i), 32'(if_gnt), 32'(tbl[i].e_if_gnt));
      chk($sformatf("tbl%0d_d_gnt", i), 32'(d_gnt), 32'(tbl[i].e_d_gnt));
      chk($sformatf("tbl%0d_mem_wen", i), 32'(mem_wen), 32'(tbl[i].e_wen));
      chk($sformatf("tbl%0d_if_rvalid", i), 32'(if_rvalid), 32'(tbl[i].e_if_rv));
      chk($sformatf("tbl%0d_if_rdata", i), if_rdata, tbl[i].e_if_rd);
      chk($sformatf("tbl%0d_d_rvalid", i), 32'(d_rvalid), 32'(tbl[i].e_d_rv));
      chk($sformatf("tbl%0d_d_rdata", i), d_rdata, tbl[i].e_d_rd);
      model_step();
      @(posedge clk);
      #1;
    end

    // Starvation: D held for 10 cycles, IF forced through at cycles 3 and 7.
    for (int i = 0; i < 10; i++) begin
      drive(1, 5, 1, 0, 40, 0);
      @(negedge clk);
      chk($sformatf("starve%0d_if_gnt", i), 32'(if_gnt), 32'((i == 3) || (i == 7)));
      model_step();
      @(posedge clk);
      #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset while an IF read is in flight.
    drive(1, 3, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_if_gnt", 32'(if_gnt), 32'd1);
    model_step();
    #2;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_mid_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("rst_mid_state", 32'(u_dut.rsp_state), 32'(RSP_NONE));
    chk("rst_mid_starve_cnt", 32'(u_dut.u_starve.cnt), 32'd0);
    model_step();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // Withdrawal: IF denied twice, then dropped without ever being granted.
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1, 8, 1, 0, 20, 0);
      else       drive(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("wd%0d_if_gnt", i), 32'(if_gnt), 32'd0);
      chk($sformatf("wd%0d_if_rvalid", i), 32'(if_rvalid), 32'd0);
      if (i == 2) chk("wd_starve_cnt_pre", 32'(u_dut.u_starve.cnt), 32'd2);
      if (i == 3) chk("wd_starve_cnt_clr", 32'(u_dut.u_starve.cnt), 32'd0);
      model_step();
      @(posedge clk);
      #1;
    end

    // Random traffic honouring the hold-until-grant protocol.
    for (int c = 0; c < 3000; c++) begin
      if (if_req && !m_if_last) begin
        if ($urandom_range(0, 9) == 0) if_req = 1'b0;
      end else begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 32'($urandom_range(0, 255));
      end
      if (d_req && !m_d_last) begin
        if ($urandom_range(0, 9) == 0) d_req = 1'b0;
      end else begin
        d_req   = 1'($urandom_range(0, 2) != 0);
        d_we    = 1'($urandom_range(0, 1));
        d_addr  = 32'($urandom_range(0, 255));
        d_wdata = $urandom;
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
